matrix_result_collector: RTL

//  Downstream of the matrix multiplicator: captures each Result word flagged by Done and queues it in a 4-entry FIFO.

---
 rtl/matrix_result_collector.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/matrix_result_collector.sv
// Collects multiplicator results in a small FIFO and writes them row-major to memory.
// Ports: Clock/ClearAll, Start/BaseAddr, Done/Error/Result in; MemWrite/MemAddr/MemData/MemReady write port; Busy/Complete/Fault status.
module matrix_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  ClearAll,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic                  Done,
  input  logic                  Error,
  input  logic [DATA_WIDTH-1:0] Result,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemData,
  input  logic                  MemReady,
  output logic                  Busy,
  output logic                  Complete,
  output logic                  Fault
);

  localparam int N  = DIM * DIM;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMPLETE,
    ABORT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           fcount;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         cap_cnt;
  logic [CW-1:0]         wr_cnt;
  logic                  fault_q;

  logic collecting;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic cap_done;
  logic err_ev;
  logic done_ev;
  logic extra_ev;
  logic overrun;
  logic last_pop;
  logic start_ev;

  assign collecting = (state == COLLECT);
  assign empty      = (fcount == '0);
  assign full       = (fcount == (PW+1)'(FIFO_DEPTH));
  assign pop        = collecting && !empty && MemReady;
  assign cap_done   = (cap_cnt == CW'(N));
  assign err_ev     = collecting && Error;
  assign done_ev    = collecting && Done && !Error;
  // Surplus Done after all N captures flags a fault but keeps draining.
  assign extra_ev   = done_ev && cap_done;
  // A full FIFO can still take a push when the head leaves this cycle.
  assign overrun    = done_ev && !cap_done && full && !pop;
  assign push       = done_ev && !cap_done && !overrun;
  assign last_pop   = pop && (wr_cnt == CW'(N - 1));
  assign start_ev   = (state == IDLE) && Start;

  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_ev) state_nx = COLLECT;
      end
      COLLECT: begin
        if (err_ev || overrun) state_nx = ABORT;
        else if (last_pop)     state_nx = COMPLETE;
      end
      COMPLETE: state_nx = IDLE;
      ABORT:    state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      fcount  <= '0;
      base_q  <= '0;
      cap_cnt <= '0;
      wr_cnt  <= '0;
      fault_q <= 1'b0;
    end else if (start_ev) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      fcount  <= '0;
      base_q  <= BaseAddr;
      cap_cnt <= '0;
      wr_cnt  <= '0;
      fault_q <= 1'b0;
    end else if (state == ABORT) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        cap_cnt <= cap_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wr_cnt <= wr_cnt + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
      if (err_ev || overrun || extra_ev) fault_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= Result;
  end

  always_comb begin
    MemWrite = collecting && !empty;
    MemAddr  = base_q + ADDR_WIDTH'(wr_cnt);
    MemData  = MemWrite ? fifo_mem[rd_ptr] : '0;
    Busy     = collecting;
    Complete = (state == COMPLETE);
    Fault    = fault_q;
  end

endmodule
